// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: PS/2 mouse frame receiver, 3-byte packet decoder and per-frame displacement accumulator
module ps2_mouse_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 5000,
    parameter bit INVERT_Y   = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       frame_tick,
    output logic [7:0] X_displ,
    output logic [7:0] Y_displ,
    output logic [2:0] Buttons,
    output logic       Pkt_valid,
    output logic       Err
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]        clk_sync_q, dat_sync_q;
    logic              filt_q, par_q, fall, dat, byte_ok;
    logic [FW-1:0]     flt_cnt_q;
    logic [TW-1:0]     to_cnt_q;
    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [1:0]        idx_q;
    logic [7:0]        shreg_q, b0_q, bx_q, dx_q, dy_q, acc_x_q, acc_y_q;
    logic signed [9:0] dx_w, dy_w, sx_w, sy_w;

    function automatic logic [7:0] sat(input logic signed [9:0] v);
        return (v > 10'sd127) ? 8'h7F : (v < -10'sd128) ? 8'h80 : v[7:0];
    endfunction

    assign dat     = dat_sync_q[1];
    assign fall    = filt_q && !clk_sync_q[1] && flt_cnt_q == FW'(FILTER_LEN - 1);
    assign byte_ok = dat && (^{shreg_q, par_q});

    // Byte 2 is still in the shift register when its stop bit arrives.
    always_comb begin
        dx_w = b0_q[6] ? (b0_q[4] ? -10'sd256 : 10'sd255) : {{2{b0_q[4]}}, bx_q};
        dy_w = b0_q[7] ? (b0_q[5] ? -10'sd256 : 10'sd255) : {{2{b0_q[5]}}, shreg_q};
        dy_w = INVERT_Y ? -dy_w : dy_w;
        sx_w = {{2{acc_x_q[7]}}, acc_x_q} + {{2{dx_q[7]}}, dx_q};
        sy_w = {{2{acc_y_q[7]}}, acc_y_q} + {{2{dy_q[7]}}, dy_q};
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
            if (clk_sync_q[1] == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q    <= clk_sync_q[1];
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            to_cnt_q  <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            b0_q      <= '0;
            bx_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            X_displ   <= '0;
            Y_displ   <= '0;
            Buttons   <= '0;
            Pkt_valid <= 1'b0;
            Err       <= 1'b0;
        end else begin
            Pkt_valid <= 1'b0;
            Err       <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        state_q   <= dat ? IDLE : DATA;
                        bit_cnt_q <= '0;
                    end
                    DATA: begin
                        shreg_q   <= {dat, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        state_q   <= (bit_cnt_q == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par_q   <= dat;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!byte_ok) begin
                            Err   <= 1'b1;
                            idx_q <= '0;
                        end else if (idx_q == 2'd0) begin
                            b0_q  <= shreg_q;
                            idx_q <= shreg_q[3] ? 2'd1 : 2'd0;
                            Err   <= !shreg_q[3];
                        end else if (idx_q == 2'd1) begin
                            bx_q  <= shreg_q;
                            idx_q <= 2'd2;
                        end else begin
                            Pkt_valid <= 1'b1;
                            Buttons   <= b0_q[2:0];
                            dx_q      <= sat(dx_w);
                            dy_q      <= sat(dy_w);
                            idx_q     <= '0;
                        end
                    end
                endcase
            end else if (state_q != IDLE && filt_q) begin
                if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_q  <= IDLE;
                    Err      <= 1'b1;
                    idx_q    <= '0;
                    to_cnt_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
            // A packet landing on a tick seeds the next frame instead of being lost.
            if (frame_tick) begin
                X_displ <= acc_x_q;
                Y_displ <= acc_y_q;
                acc_x_q <= Pkt_valid ? dx_q : 8'h00;
                acc_y_q <= Pkt_valid ? dy_q : 8'h00;
            end else if (Pkt_valid) begin
                acc_x_q <= sat(sx_w);
                acc_y_q <= sat(sy_w);
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx: table-driven packet vectors with a button scoreboard, plus error/timeout/tick corner sequences
module tb_ps2_mouse_rx;
    typedef struct {
        logic       send;
        logic [7:0] b0, b1, b2;
        logic       tick;
        logic [2:0] eb;
        logic [7:0] ex, ey;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1, tick = 1'b0;
    logic [7:0] x_displ, y_displ;
    logic [2:0] buttons;
    logic       pkt_valid, err;
    int         total = 0, bad = 0, err_seen = 0;
    logic [2:0] exp_q[$];
    logic       pv_prev = 1'b0, er_prev = 1'b0;
    vec_t       vecs[14];

    always #10 clk = ~clk;

    ps2_mouse_rx dut (
        .Clk(clk), .Reset_n(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .frame_tick(tick),
        .X_displ(x_displ), .Y_displ(y_displ), .Buttons(buttons), .Pkt_valid(pkt_valid), .Err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_valid) begin
                check("pkt_valid_single", {31'd0, pv_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pkt: got Pkt_valid with buttons %0h, expected none", buttons);
                end else begin
                    check("buttons", {29'd0, buttons}, {29'd0, exp_q.pop_front()});
                end
            end
            if (err) begin
                err_seen++;
                check("err_single", {31'd0, er_prev}, 32'd0);
            end
        end
        pv_prev = pkt_valid;
        er_prev = err;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            cyc(10);
            ps2_clk = 1'b0;
            cyc(20);
            ps2_clk = 1'b1;
            cyc(10);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_bits({1'b1, (~^b) ^ bad_par, b, 1'b0}, 11);
        ps2_dat = 1'b1;
        cyc(30);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [2:0] eb);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        exp_q.push_back(eb);
        send_byte(b2, 1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) cyc(1);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d packets still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_tick(input logic [7:0] ex, input logic [7:0] ey, input string nm);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        check({nm, "_x"}, {24'd0, x_displ}, {24'd0, ex});
        check({nm, "_y"}, {24'd0, y_displ}, {24'd0, ey});
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        bit got;
        vecs[0]  = '{1'b1, 8'h09, 8'h05, 8'hFD, 1'b1, 3'b001, 8'h05, 8'h80};
        vecs[1]  = '{1'b1, 8'h29, 8'h05, 8'hFD, 1'b1, 3'b001, 8'h05, 8'h03};
        vecs[2]  = '{1'b1, 8'h08, 8'h64, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 8'h08, 8'h64, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'h08, 8'h64, 8'h00, 1'b1, 3'b000, 8'h7F, 8'h00};
        vecs[5]  = '{1'b1, 8'h48, 8'h00, 8'h00, 1'b1, 3'b000, 8'h7F, 8'h00};
        vecs[6]  = '{1'b1, 8'h58, 8'h00, 8'h00, 1'b1, 3'b000, 8'h80, 8'h00};
        vecs[7]  = '{1'b1, 8'h88, 8'h00, 8'h00, 1'b1, 3'b000, 8'h00, 8'h80};
        vecs[8]  = '{1'b1, 8'hA8, 8'h00, 8'h00, 1'b1, 3'b000, 8'h00, 8'h7F};
        vecs[9]  = '{1'b1, 8'h0F, 8'h80, 8'h7F, 1'b1, 3'b111, 8'h7F, 8'h81};
        vecs[10] = '{1'b1, 8'h3A, 8'hFF, 8'h01, 1'b1, 3'b010, 8'hFF, 8'h7F};
        vecs[11] = '{1'b1, 8'h18, 8'h9C, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00};
        vecs[12] = '{1'b1, 8'h18, 8'h9C, 8'h00, 1'b1, 3'b000, 8'h80, 8'h00};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 8'h00, 8'h00};

        cyc(5);
        check("reset_x", {24'd0, x_displ}, 32'd0);
        check("reset_y", {24'd0, y_displ}, 32'd0);
        check("reset_buttons", {29'd0, buttons}, 32'd0);
        check("reset_pv_err", {30'd0, pkt_valid, err}, 32'd0);
        rst_n = 1'b1;
        cyc(20);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].send) send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].eb);
            wait_drain();
            if (vecs[i].tick) do_tick(vecs[i].ex, vecs[i].ey, $sformatf("vec%0d", i));
        end
        check("vec_no_err", err_seen, 32'd0);

        base = err_seen;
        send_byte(8'h09, 1'b0);
        send_byte(8'h05, 1'b1);
        check("parity_err", err_seen - base, 32'd1);
        send_pkt(8'h29, 8'h05, 8'hFD, 3'b001);
        wait_drain();
        do_tick(8'h05, 8'h03, "after_parity");

        base = err_seen;
        send_byte(8'h01, 1'b0);
        check("sync_err", err_seen - base, 32'd1);
        send_pkt(8'h29, 8'h05, 8'hFD, 3'b001);
        wait_drain();
        do_tick(8'h05, 8'h03, "after_sync");
        check("sync_err_once", err_seen - base, 32'd1);

        base = err_seen;
        n = 0;
        send_bits({1'b1, ~^8'h29, 8'h29, 1'b0}, 5);
        ps2_dat = 1'b1;
        while (err_seen == base && n < 6000) begin
            cyc(1);
            n++;
        end
        check("timeout_err", err_seen - base, 32'd1);
        total++;
        if (n < 4980 || n > 5020) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles, expected about 5000", n);
        end
        if (n < 6000) cyc(6000 - n);
        send_pkt(8'h29, 8'h05, 8'hFD, 3'b001);
        wait_drain();
        do_tick(8'h05, 8'h03, "after_timeout");
        check("timeout_err_once", err_seen - base, 32'd1);

        send_pkt(8'h08, 8'h02, 8'h00, 3'b000);
        wait_drain();
        send_byte(8'h08, 1'b0);
        send_byte(8'h03, 1'b0);
        exp_q.push_back(3'b000);
        got = 1'b0;
        fork
            send_byte(8'h00, 1'b0);
            for (int i = 0; i < 1000 && !got; i++) begin
                @(negedge clk);
                if (pkt_valid) begin
                    tick = 1'b1;
                    cyc(1);
                    tick = 1'b0;
                    got = 1'b1;
                end
            end
        join
        if (!got) begin
            total++;
            bad++;
            $display("FAIL coincide_wait: got no Pkt_valid, expected one within 1000 cycles");
        end
        check("coincide_x", {24'd0, x_displ}, 32'h02);
        wait_drain();
        do_tick(8'h03, 8'h00, "coincide_next");

        base = err_seen;
        send_pkt(8'h08, 8'h05, 8'h00, 3'b000);
        wait_drain();
        send_byte(8'h08, 1'b0);
        send_bits({1'b1, ~^8'h07, 8'h07, 1'b0}, 3);
        ps2_dat = 1'b1;
        rst_n = 1'b0;
        cyc(3);
        check("midreset_x", {24'd0, x_displ}, 32'd0);
        rst_n = 1'b1;
        cyc(20);
        send_pkt(8'h08, 8'h03, 8'h00, 3'b000);
        wait_drain();
        do_tick(8'h03, 8'h00, "after_reset");
        check("reset_no_err", err_seen - base, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
